// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with optional M-extension,
// illegal-instruction detection, ECALL/EBREAK halt detection, a halt lock
// and flush. One pipeline register sits between fetch and register-read.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// the producer's valid and the consumer's ready are both 1. The producer
// holds its valid (and payload) stable until the transfer happens. in_ready
// is combinational: the stage is running, its single slot is empty or
// draining this cycle, and no flush is requested. While out_valid=1 and
// out_ready=0 every output holds stable.
module decode_stage #(
  parameter int ENABLE_M  = 1,
  parameter int ALUCODE_W = 6,
  parameter int PC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_ir,
  input  logic [PC_W-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_W-1:0]      out_pc,
  output logic [4:0]           srcreg1_num,
  output logic [4:0]           srcreg2_num,
  output logic [4:0]           dstreg_num,
  output logic [31:0]          imm,
  output logic [ALUCODE_W-1:0] alucode,
  output logic [1:0]           aluop1_type,
  output logic [1:0]           aluop2_type,
  output logic                 reg_we,
  output logic                 is_load,
  output logic                 is_store,
  output logic                 is_halt,
  output logic                 is_illegal,
  output logic                 dbg_state
);

  // Operand source encodings
  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [1:0] OP_TYPE_REG  = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
  localparam logic [1:0] OP_TYPE_PC   = 2'd3;

  // ALU operation encodings
  localparam logic [ALUCODE_W-1:0] ALU_LUI    = ALUCODE_W'(0);
  localparam logic [ALUCODE_W-1:0] ALU_JAL    = ALUCODE_W'(1);
  localparam logic [ALUCODE_W-1:0] ALU_JALR   = ALUCODE_W'(2);
  localparam logic [ALUCODE_W-1:0] ALU_BEQ    = ALUCODE_W'(3);
  localparam logic [ALUCODE_W-1:0] ALU_BNE    = ALUCODE_W'(4);
  localparam logic [ALUCODE_W-1:0] ALU_BLT    = ALUCODE_W'(5);
  localparam logic [ALUCODE_W-1:0] ALU_BGE    = ALUCODE_W'(6);
  localparam logic [ALUCODE_W-1:0] ALU_BLTU   = ALUCODE_W'(7);
  localparam logic [ALUCODE_W-1:0] ALU_BGEU   = ALUCODE_W'(8);
  localparam logic [ALUCODE_W-1:0] ALU_LB     = ALUCODE_W'(9);
  localparam logic [ALUCODE_W-1:0] ALU_LH     = ALUCODE_W'(10);
  localparam logic [ALUCODE_W-1:0] ALU_LW     = ALUCODE_W'(11);
  localparam logic [ALUCODE_W-1:0] ALU_LBU    = ALUCODE_W'(12);
  localparam logic [ALUCODE_W-1:0] ALU_LHU    = ALUCODE_W'(13);
  localparam logic [ALUCODE_W-1:0] ALU_SB     = ALUCODE_W'(14);
  localparam logic [ALUCODE_W-1:0] ALU_SH     = ALUCODE_W'(15);
  localparam logic [ALUCODE_W-1:0] ALU_SW     = ALUCODE_W'(16);
  localparam logic [ALUCODE_W-1:0] ALU_ADD    = ALUCODE_W'(17);
  localparam logic [ALUCODE_W-1:0] ALU_SUB    = ALUCODE_W'(18);
  localparam logic [ALUCODE_W-1:0] ALU_XOR    = ALUCODE_W'(19);
  localparam logic [ALUCODE_W-1:0] ALU_OR     = ALUCODE_W'(20);
  localparam logic [ALUCODE_W-1:0] ALU_AND    = ALUCODE_W'(21);
  localparam logic [ALUCODE_W-1:0] ALU_SLT    = ALUCODE_W'(22);
  localparam logic [ALUCODE_W-1:0] ALU_SLTU   = ALUCODE_W'(23);
  localparam logic [ALUCODE_W-1:0] ALU_SLL    = ALUCODE_W'(24);
  localparam logic [ALUCODE_W-1:0] ALU_SRL    = ALUCODE_W'(25);
  localparam logic [ALUCODE_W-1:0] ALU_SRA    = ALUCODE_W'(26);
  localparam logic [ALUCODE_W-1:0] ALU_MUL    = ALUCODE_W'(27);
  localparam logic [ALUCODE_W-1:0] ALU_MULH   = ALUCODE_W'(28);
  localparam logic [ALUCODE_W-1:0] ALU_MULHSU = ALUCODE_W'(29);
  localparam logic [ALUCODE_W-1:0] ALU_MULHU  = ALUCODE_W'(30);
  localparam logic [ALUCODE_W-1:0] ALU_DIV    = ALUCODE_W'(31);
  localparam logic [ALUCODE_W-1:0] ALU_DIVU   = ALUCODE_W'(32);
  localparam logic [ALUCODE_W-1:0] ALU_REM    = ALUCODE_W'(33);
  localparam logic [ALUCODE_W-1:0] ALU_REMU   = ALUCODE_W'(34);

  // Major opcodes (ir[6:0], low two bits must be 11)
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0]  F7_BASE   = 7'b0000000;
  localparam logic [6:0]  F7_ALT    = 7'b0100000;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;
  localparam logic [31:0] IR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] IR_EBREAK = 32'h0010_0073;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                 state_q;
  logic                   valid_q;
  logic [PC_W-1:0]        pc_q;
  logic [4:0]             rs1_q, rs2_q, rd_q;
  logic [31:0]            imm_q;
  logic [ALUCODE_W-1:0]   alu_q;
  logic [1:0]             t1_q, t2_q;
  logic                   we_q, ld_q, st_q, halt_q, ill_q;

  logic [4:0]             rs1_d, rs2_d, rd_d;
  logic [31:0]            imm_d;
  logic [ALUCODE_W-1:0]   alu_d;
  logic [1:0]             t1_d, t2_d;
  logic                   we_d, ld_d, st_d, halt_d, ill_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        accept;

  assign opcode = in_ir[6:0];
  assign funct3 = in_ir[14:12];
  assign funct7 = in_ir[31:25];

  assign imm_i  = {{20{in_ir[31]}}, in_ir[31:20]};
  assign imm_s  = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
  assign imm_b  = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
  assign imm_u  = {in_ir[31:12], 12'h000};
  assign imm_j  = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
  assign imm_sh = {27'b0, in_ir[24:20]};

  assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Decode the incoming word into next bundle fields; illegal words collapse to an inert bundle
  always_comb begin
    rs1_d  = '0;
    rs2_d  = '0;
    rd_d   = '0;
    imm_d  = '0;
    alu_d  = '0;
    t1_d   = OP_TYPE_NONE;
    t2_d   = OP_TYPE_NONE;
    we_d   = 1'b0;
    ld_d   = 1'b0;
    st_d   = 1'b0;
    halt_d = 1'b0;
    ill_d  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        rd_d  = in_ir[11:7];
        imm_d = imm_u;
        alu_d = ALU_LUI;
        t2_d  = OP_TYPE_IMM;
        we_d  = 1'b1;
      end
      OPC_AUIPC: begin
        rd_d  = in_ir[11:7];
        imm_d = imm_u;
        alu_d = ALU_ADD;
        t1_d  = OP_TYPE_IMM;
        t2_d  = OP_TYPE_PC;
        we_d  = 1'b1;
      end
      OPC_JAL: begin
        rd_d  = in_ir[11:7];
        imm_d = imm_j;
        alu_d = ALU_JAL;
        t2_d  = OP_TYPE_PC;
        we_d  = |in_ir[11:7];
      end
      OPC_JALR: begin
        rs1_d = in_ir[19:15];
        rd_d  = in_ir[11:7];
        imm_d = imm_i;
        alu_d = ALU_JALR;
        t1_d  = OP_TYPE_REG;
        t2_d  = OP_TYPE_PC;
        we_d  = |in_ir[11:7];
      end
      OPC_BRANCH: begin
        rs1_d = in_ir[19:15];
        rs2_d = in_ir[24:20];
        imm_d = imm_b;
        t1_d  = OP_TYPE_REG;
        t2_d  = OP_TYPE_REG;
        case (funct3)
          3'd0:    alu_d = ALU_BEQ;
          3'd1:    alu_d = ALU_BNE;
          3'd4:    alu_d = ALU_BLT;
          3'd5:    alu_d = ALU_BGE;
          3'd6:    alu_d = ALU_BLTU;
          3'd7:    alu_d = ALU_BGEU;
          default: ill_d = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        rs1_d = in_ir[19:15];
        rd_d  = in_ir[11:7];
        imm_d = imm_i;
        t1_d  = OP_TYPE_REG;
        t2_d  = OP_TYPE_IMM;
        we_d  = 1'b1;
        ld_d  = 1'b1;
        case (funct3)
          3'd0:    alu_d = ALU_LB;
          3'd1:    alu_d = ALU_LH;
          3'd2:    alu_d = ALU_LW;
          3'd4:    alu_d = ALU_LBU;
          3'd5:    alu_d = ALU_LHU;
          default: ill_d = 1'b1;
        endcase
      end
      OPC_STORE: begin
        rs1_d = in_ir[19:15];
        rs2_d = in_ir[24:20];
        imm_d = imm_s;
        t1_d  = OP_TYPE_REG;
        t2_d  = OP_TYPE_IMM;
        st_d  = 1'b1;
        case (funct3)
          3'd0:    alu_d = ALU_SB;
          3'd1:    alu_d = ALU_SH;
          3'd2:    alu_d = ALU_SW;
          default: ill_d = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        rs1_d = in_ir[19:15];
        rd_d  = in_ir[11:7];
        imm_d = imm_i;
        t1_d  = OP_TYPE_REG;
        t2_d  = OP_TYPE_IMM;
        we_d  = 1'b1;
        case (funct3)
          3'd0: alu_d = ALU_ADD;
          3'd2: alu_d = ALU_SLT;
          3'd3: alu_d = ALU_SLTU;
          3'd4: alu_d = ALU_XOR;
          3'd6: alu_d = ALU_OR;
          3'd7: alu_d = ALU_AND;
          3'd1: begin
            alu_d = ALU_SLL;
            imm_d = imm_sh;
            if (funct7 != F7_BASE) ill_d = 1'b1;
          end
          default: begin
            imm_d = imm_sh;
            if (funct7 == F7_BASE)     alu_d = ALU_SRL;
            else if (funct7 == F7_ALT) alu_d = ALU_SRA;
            else                       ill_d = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        rs1_d = in_ir[19:15];
        rs2_d = in_ir[24:20];
        rd_d  = in_ir[11:7];
        t1_d  = OP_TYPE_REG;
        t2_d  = OP_TYPE_REG;
        we_d  = 1'b1;
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M != 0) begin
            case (funct3)
              3'd0:    alu_d = ALU_MUL;
              3'd1:    alu_d = ALU_MULH;
              3'd2:    alu_d = ALU_MULHSU;
              3'd3:    alu_d = ALU_MULHU;
              3'd4:    alu_d = ALU_DIV;
              3'd5:    alu_d = ALU_DIVU;
              3'd6:    alu_d = ALU_REM;
              default: alu_d = ALU_REMU;
            endcase
          end else begin
            ill_d = 1'b1;
          end
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            3'd0:    alu_d = ALU_ADD;
            3'd1:    alu_d = ALU_SLL;
            3'd2:    alu_d = ALU_SLT;
            3'd3:    alu_d = ALU_SLTU;
            3'd4:    alu_d = ALU_XOR;
            3'd5:    alu_d = ALU_SRL;
            3'd6:    alu_d = ALU_OR;
            default: alu_d = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'd0)      alu_d = ALU_SUB;
          else if (funct3 == 3'd5) alu_d = ALU_SRA;
          else                     ill_d = 1'b1;
        end else begin
          ill_d = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        // Only the exact ECALL/EBREAK words stop the core; everything else is rejected
        if (in_ir == IR_ECALL || in_ir == IR_EBREAK) halt_d = 1'b1;
        else                                         ill_d  = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
    if (ill_d) begin
      rs1_d = '0;
      rs2_d = '0;
      rd_d  = '0;
      imm_d = '0;
      alu_d = '0;
      t1_d  = OP_TYPE_NONE;
      t2_d  = OP_TYPE_NONE;
      we_d  = 1'b0;
      ld_d  = 1'b0;
      st_d  = 1'b0;
    end
  end

  // Halt-lock FSM and the single pipeline slot; flush beats accept/drain, reset beats flush
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      t1_q    <= OP_TYPE_NONE;
      t2_q    <= OP_TYPE_NONE;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      halt_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      halt_q  <= halt_d;
      ill_q   <= ill_d;
      if (halt_d) state_q <= ST_HALTED;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign srcreg1_num = rs1_q;
  assign srcreg2_num = rs2_q;
  assign dstreg_num  = rd_q;
  assign imm         = imm_q;
  assign alucode     = alu_q;
  assign aluop1_type = t1_q;
  assign aluop2_type = t2_q;
  assign reg_we      = we_q;
  assign is_load     = ld_q;
  assign is_store    = st_q;
  assign is_halt     = halt_q;
  assign is_illegal  = ill_q;
  assign dbg_state   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized checks of decode_stage, with one
// instance built with the M-extension and one without, against a queue-based
// reference model of the pipeline slot and a field-level decoder model.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  t1;
    logic [1:0]  t2;
    logic        we;
    logic        ld;
    logic        st;
    logic        halt;
    logic        ill;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  // ALU / operand encodings
  localparam logic [5:0] A_LUI = 6'd0, A_JAL = 6'd1, A_JALR = 6'd2, A_ADD = 6'd17,
                         A_SUB = 6'd18, A_SRA = 6'd26, A_MUL = 6'd27;
  localparam logic [1:0] T_NONE = 2'd0, T_REG = 2'd1, T_IMM = 2'd2, T_PC = 2'd3;

  // Per-funct3 ALU tables (index = funct3)
  logic [5:0] br_alu  [8] = '{6'd3, 6'd4, 6'd0, 6'd0, 6'd5, 6'd6, 6'd7, 6'd8};
  logic [5:0] ld_alu  [8] = '{6'd9, 6'd10, 6'd11, 6'd0, 6'd12, 6'd13, 6'd0, 6'd0};
  logic [5:0] st_alu  [8] = '{6'd14, 6'd15, 6'd16, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
  logic [5:0] ari_alu [8] = '{6'd17, 6'd24, 6'd22, 6'd23, 6'd19, 6'd25, 6'd20, 6'd21};
  logic [6:0] legal_ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_ir, in_pc;

  logic        rdy1, ov1, we1, ld1, st1, ht1, il1, dbg1;
  logic [31:0] pc1, imm1;
  logic [4:0]  rs1_1, rs2_1, rd1;
  logic [5:0]  alu1;
  logic [1:0]  t1_1, t2_1;

  logic        rdy0, ov0, we0, ld0, st0, ht0, il0, dbg0;
  logic [31:0] pc0, imm0;
  logic [4:0]  rs1_0, rs2_0, rd0;
  logic [5:0]  alu0;
  logic [1:0]  t1_0, t2_0;

  decode_stage #(.ENABLE_M(1), .ALUCODE_W(6), .PC_W(32)) dut_m1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_ir(in_ir),
    .in_pc(in_pc), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_pc(pc1), .srcreg1_num(rs1_1), .srcreg2_num(rs2_1), .dstreg_num(rd1),
    .imm(imm1), .alucode(alu1), .aluop1_type(t1_1), .aluop2_type(t2_1),
    .reg_we(we1), .is_load(ld1), .is_store(st1), .is_halt(ht1),
    .is_illegal(il1), .dbg_state(dbg1)
  );

  decode_stage #(.ENABLE_M(0), .ALUCODE_W(6), .PC_W(32)) dut_m0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_ir(in_ir),
    .in_pc(in_pc), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_pc(pc0), .srcreg1_num(rs1_0), .srcreg2_num(rs2_0), .dstreg_num(rd0),
    .imm(imm0), .alucode(alu0), .aluop1_type(t1_0), .aluop2_type(t2_0),
    .reg_we(we0), .is_load(ld0), .is_store(st0), .is_halt(ht0),
    .is_illegal(il0), .dbg_state(dbg0)
  );

  bundle_t obs1, obs0;
  assign obs1 = {pc1, rs1_1, rs2_1, rd1, imm1, alu1, t1_1, t2_1, we1, ld1, st1, ht1, il1};
  assign obs0 = {pc0, rs1_0, rs2_0, rd0, imm0, alu0, t1_0, t2_0, we0, ld0, st0, ht0, il0};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q1[$];
  logic [BW-1:0] exp_q0[$];
  logic halted;
  logic exp_rdy;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decoder, written directly from the instruction-format rules
  function automatic bundle_t ref_decode(input logic [31:0] ir, input logic [31:0] pc, input bit en_m);
    bundle_t b;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] r1, r2, rd;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
    r1 = ir[19:15]; r2 = ir[24:20]; rd = ir[11:7];
    i_imm = {{20{ir[31]}}, ir[31:20]};
    s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    u_imm = {ir[31:12], 12'h000};
    j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    b = '0;
    if (op == 7'h37) begin
      b.rd = rd; b.imm = u_imm; b.alu = A_LUI; b.t2 = T_IMM; b.we = 1'b1;
    end else if (op == 7'h17) begin
      b.rd = rd; b.imm = u_imm; b.alu = A_ADD; b.t1 = T_IMM; b.t2 = T_PC; b.we = 1'b1;
    end else if (op == 7'h6f) begin
      b.rd = rd; b.imm = j_imm; b.alu = A_JAL; b.t2 = T_PC; b.we = (rd != 0);
    end else if (op == 7'h67) begin
      b.rs1 = r1; b.rd = rd; b.imm = i_imm; b.alu = A_JALR; b.t1 = T_REG; b.t2 = T_PC;
      b.we = (rd != 0);
    end else if (op == 7'h63) begin
      b.rs1 = r1; b.rs2 = r2; b.imm = b_imm; b.alu = br_alu[f3]; b.t1 = T_REG; b.t2 = T_REG;
      b.ill = (f3 == 2 || f3 == 3);
    end else if (op == 7'h03) begin
      b.rs1 = r1; b.rd = rd; b.imm = i_imm; b.alu = ld_alu[f3]; b.t1 = T_REG; b.t2 = T_IMM;
      b.we = 1'b1; b.ld = 1'b1; b.ill = (f3 == 3 || f3 >= 6);
    end else if (op == 7'h23) begin
      b.rs1 = r1; b.rs2 = r2; b.imm = s_imm; b.alu = st_alu[f3]; b.t1 = T_REG; b.t2 = T_IMM;
      b.st = 1'b1; b.ill = (f3 > 2);
    end else if (op == 7'h13) begin
      b.rs1 = r1; b.rd = rd; b.t1 = T_REG; b.t2 = T_IMM; b.we = 1'b1;
      b.imm = (f3 == 1 || f3 == 5) ? {27'b0, ir[24:20]} : i_imm;
      b.alu = (f3 == 5 && f7 == 7'h20) ? A_SRA : ari_alu[f3];
      b.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
    end else if (op == 7'h33) begin
      b.rs1 = r1; b.rs2 = r2; b.rd = rd; b.t1 = T_REG; b.t2 = T_REG; b.we = 1'b1;
      if (f7 == 7'h01) begin
        b.alu = A_MUL + 6'(f3); b.ill = !en_m;
      end else if (f7 == 7'h00) begin
        b.alu = ari_alu[f3];
      end else if (f7 == 7'h20) begin
        b.alu = (f3 == 0) ? A_SUB : A_SRA; b.ill = !(f3 == 0 || f3 == 5);
      end else begin
        b.ill = 1'b1;
      end
    end else if (ir == 32'h0000_0073 || ir == 32'h0010_0073) begin
      b.halt = 1'b1;
    end else begin
      b.ill = 1'b1;
    end
    if (b.ill) begin
      b = '0;
      b.ill = 1'b1;
    end
    b.pc = pc;
    return b;
  endfunction

  // Illegal and halt bundles leave imm/alucode/operand types unconstrained
  function automatic bundle_t view(input bundle_t b, input bundle_t ref_b);
    bundle_t v;
    v = b;
    if (ref_b.ill || ref_b.halt) begin
      v.imm = '0; v.alu = '0; v.t1 = '0; v.t2 = '0;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] w;
    int sel, k;
    w = $urandom;
    sel = $urandom_range(0, 99);
    if (sel < 2) w = 32'h0000_0073;
    else if (sel < 4) w = 32'h0010_0073;
    else if (sel < 8) w[6:0] = 7'h73;
    else if (sel >= 12) begin
      w[6:0] = legal_ops[$urandom_range(0, 8)];
      k = $urandom_range(0, 4);
      if (k == 0) w[31:25] = 7'h00;
      else if (k == 1) w[31:25] = 7'h20;
      else if (k == 2) w[31:25] = 7'h01;
    end
    return w;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle of inputs, compare against the model mid-cycle, advance the model
  task automatic step(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rs);
    bundle_t e, b1, b0;
    rst = rs; in_valid = v; in_ir = ir; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    exp_rdy = !halted && (exp_q1.size() == 0 || out_ready) && !flush;
    check("in_ready_m1", rdy1, exp_rdy);
    check("in_ready_m0", rdy0, exp_rdy);
    check("halted_m1", dbg1, halted);
    check("halted_m0", dbg0, halted);
    check("out_valid_m1", ov1, exp_q1.size() != 0);
    check("out_valid_m0", ov0, exp_q0.size() != 0);
    if (exp_q1.size() != 0) begin
      e = exp_q1[0];
      check("bundle_m1", view(obs1, e), view(e, e));
    end
    if (exp_q0.size() != 0) begin
      e = exp_q0[0];
      check("bundle_m0", view(obs0, e), view(e, e));
    end
    if (rst || flush) begin
      exp_q1.delete(); exp_q0.delete(); halted = 1'b0;
    end else begin
      if (exp_q1.size() != 0 && out_ready) begin
        void'(exp_q1.pop_front());
        void'(exp_q0.pop_front());
      end
      if (in_valid && exp_rdy) begin
        b1 = ref_decode(in_ir, in_pc, 1'b1);
        b0 = ref_decode(in_ir, in_pc, 1'b0);
        exp_q1.push_back(b1);
        exp_q0.push_back(b0);
        if (b1.halt) halted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", ov1, 1'b0);
    check("rst_fields_m1", obs1, '0);
    check("rst_fields_m0", obs0, '0);
    check("rst_in_ready", rdy1, 1'b1);

    // addi x1,x0,5
    step(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, 1'b0);
    check("addi_valid", ov1, 1'b1);
    check("addi_rd", rd1, 5'd1);
    check("addi_rs1", rs1_1, 5'd0);
    check("addi_imm", imm1, 32'd5);
    check("addi_alu", alu1, A_ADD);
    check("addi_t2", t2_1, T_IMM);
    check("addi_we", we1, 1'b1);
    check("addi_ill", il1, 1'b0);

    // mul x3,x1,x2 in both configurations
    step(1'b1, 32'h0220_81B3, 32'h104, 1'b1, 1'b0, 1'b0);
    check("mul_alu", alu1, A_MUL);
    check("mul_rs1", rs1_1, 5'd1);
    check("mul_rs2", rs2_1, 5'd2);
    check("mul_rd", rd1, 5'd3);
    check("mul_we", we1, 1'b1);
    check("mul_noM_ill", il0, 1'b1);
    check("mul_noM_we", we0, 1'b0);

    // srai x5,x6,3 then jal x0,0
    step(1'b1, 32'h4033_5293, 32'h108, 1'b1, 1'b0, 1'b0);
    check("srai_alu", alu1, A_SRA);
    check("srai_imm", imm1, 32'd3);
    step(1'b1, 32'h0000_006F, 32'h10c, 1'b1, 1'b0, 1'b0);
    check("jal_we", we1, 1'b0);
    check("jal_alu", alu1, A_JAL);

    // Backpressure with a second instruction waiting
    step(1'b1, 32'h0010_0113, 32'h110, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0020_0193, 32'h114, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready", rdy1, 1'b0);
      check("bp_rd_hold", rd1, 5'd2);
      check("bp_pc_hold", pc1, 32'h110);
    end
    step(1'b1, 32'h0020_0193, 32'h114, 1'b1, 1'b0, 1'b0);
    check("bp_second_rd", rd1, 5'd3);
    check("bp_second_imm", imm1, 32'd2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("bp_drained", ov1, 1'b0);

    // Halt lock, then flush while the halt bundle is still held
    step(1'b1, 32'h0000_0073, 32'h200, 1'b1, 1'b0, 1'b0);
    check("halt_flag", ht1, 1'b1);
    check("halt_we", we1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h0050_0093, 32'h204, 1'b0, 1'b0, 1'b0);
      check("halt_in_ready", rdy1, 1'b0);
    end
    step(1'b1, 32'h0050_0093, 32'h204, 1'b0, 1'b1, 1'b0);
    check("flush_out_valid", ov1, 1'b0);
    check("flush_state", dbg1, 1'b0);
    flush = 1'b0; out_ready = 1'b1;
    #1;
    check("flush_in_ready", rdy1, 1'b1);

    // flush beats a would-be accept
    step(1'b1, 32'h0050_0093, 32'h208, 1'b1, 1'b1, 1'b0);
    check("flush_no_accept", ov1, 1'b0);

    // Illegal branch, then reset with it held
    step(1'b1, 32'h0000_2063, 32'h300, 1'b1, 1'b0, 1'b0);
    check("bad_branch_ill", il1, 1'b1);
    check("bad_branch_valid", ov1, 1'b1);
    step(1'b1, 32'h0050_0093, 32'h304, 1'b0, 1'b0, 1'b1);
    check("rst2_out_valid", ov1, 1'b0);
    check("rst2_fields", obs1, '0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 7, rand_ir(), $urandom & 32'hffff_fffc,
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) == 0);
    end
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
